// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU command types.
//   alu_op_e  - 3-bit opcode, carried opaquely by the command queue
//   alu_cmd_t - {op, a, b} at the default 8-bit operand width
//   qstate_e  - command-queue occupancy state
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    XOR  = 3'd4,
    SHL  = 3'd5,
    SHR  = 3'd6,
    PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e              op;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } qstate_e;

endpackage

// File: rtl/alu_cmd_mem.sv
// alu_cmd_mem: DEPTH-entry command storage for alu_cmd_queue.
//   clk_i, rst_ni          - clock, async active-low clear of all entries
//   we_i, waddr_i          - synchronous write enable / address
//   wop_i, wa_i, wb_i      - command written
//   raddr_i                - asynchronous read address
//   rop_o, ra_o, rb_o      - command stored at raddr_i
module alu_cmd_mem
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  alu_op_e          wop_i,
  input  logic [WIDTH-1:0] wa_i,
  input  logic [WIDTH-1:0] wb_i,
  input  logic [AW-1:0]    raddr_i,
  output alu_op_e          rop_o,
  output logic [WIDTH-1:0] ra_o,
  output logic [WIDTH-1:0] rb_o
);

  typedef struct packed {
    alu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= '{op: wop_i, a: wa_i, b: wb_i};
    end
  end

  always_comb begin
    rop_o = mem_q[raddr_i].op;
    ra_o  = mem_q[raddr_i].a;
    rb_o  = mem_q[raddr_i].b;
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: FIFO buffer of ALU commands between the command generator
// and the ALU command port.
//   clk, reset (async, active-low), flush (sync clear)
//   in_valid/in_ready/in_op/in_a/in_b      - producer side
//   out_valid/out_ready/out_op/out_a/out_b - ALU side (head of queue)
//   count                                  - occupied entries
// Optional: define ALU_CMD_QUEUE_BYPASS_EN for a zero-latency path when
// the queue is empty.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  alu_op_e                    in_op,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output alu_op_e                    out_op,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  qstate_e       state_q, state_d;

  logic             push, pop, store, bypass;
  alu_op_e          mem_op;
  logic [WIDTH-1:0] mem_a, mem_b;

  always_comb begin
    // Handshake flags come from the registered state only, so out_ready
    // never reaches in_ready combinationally.
    in_ready = (state_q != Q_FULL) && !flush;
`ifdef ALU_CMD_QUEUE_BYPASS_EN
    bypass   = (state_q == Q_EMPTY) && in_valid && !flush;
`else
    bypass   = 1'b0;
`endif
    out_valid = (state_q != Q_EMPTY) || bypass;
    push      = in_valid && in_ready;
    pop       = (state_q != Q_EMPTY) && out_ready && !flush;
    // A bypassed command taken by the ALU this cycle is never written.
    store     = push && !(bypass && out_ready);

    count_d = count_q;
    if (store && !pop)      count_d = count_q + CW'(1);
    else if (pop && !store) count_d = count_q - CW'(1);

    if (count_d == '0)                 state_d = Q_EMPTY;
    else if (count_d == CW'(DEPTH))    state_d = Q_FULL;
    else                               state_d = Q_PARTIAL;

    out_op = bypass ? in_op : mem_op;
    out_a  = bypass ? in_a  : mem_a;
    out_b  = bypass ? in_b  : mem_b;
    count  = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= Q_EMPTY;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= Q_EMPTY;
    end else begin
      if (store) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  alu_cmd_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wop_i   (in_op),
    .wa_i    (in_a),
    .wb_i    (in_b),
    .raddr_i (rd_ptr_q),
    .rop_o   (mem_op),
    .ra_o    (mem_a),
    .rb_o    (mem_b)
  );

endmodule
